// File: rtl/muldiv_seq.sv
// muldiv_seq: radix-2 iterative signed/unsigned multiply/divide, one iteration per cycle.
// Define MULDIV_EARLY_TERM_EN to let multiply exit once the remaining multiplier bits are zero.
module muldiv_seq #(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic [1:0]         op_i,
    input  logic [WIDTH-1:0]   op1_i,
    input  logic [WIDTH-1:0]   op2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);
    typedef enum logic [1:0] {IDLE, DIVZERO, RUN, END} state_t;
    state_t state_q, state_d;
    logic [1:0]       op_q;
    logic             s1_q, s2_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div, is_signed, div_by_zero, last, done, ge, neg;
    logic [WIDTH-1:0] abs1, abs2, hi_n, lo_n, quo, rem;
    logic [WIDTH:0]   acc_sum, r_sh, r_dif;
    logic [2*WIDTH-1:0] prod_raw, fin;

    assign is_div      = op_q[1];
    assign is_signed   = op_q[0];
    assign div_by_zero = op_i[1] && op2_i == '0;
    assign abs1        = (op_i[0] && op1_i[WIDTH-1]) ? -op1_i : op1_i;
    assign abs2        = (op_i[0] && op2_i[WIDTH-1]) ? -op2_i : op2_i;
    // hi accumulates the product (mul) or holds the partial remainder (div)
    assign acc_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    assign r_sh    = {hi_q, lo_q[WIDTH-1]};
    assign r_dif   = r_sh - {1'b0, b_q};
    assign ge      = r_sh >= {1'b0, b_q};
    assign hi_n    = is_div ? (ge ? r_dif[WIDTH-1:0] : r_sh[WIDTH-1:0]) : acc_sum[WIDTH:1];
    assign lo_n    = is_div ? {lo_q[WIDTH-2:0], ge} : {acc_sum[0], lo_q[WIDTH-1:1]};
    assign last    = cnt_q == CNT_W'(WIDTH - 1);
`ifdef MULDIV_EARLY_TERM_EN
    logic [CNT_W-1:0] iters;
    assign iters    = cnt_q + 1'b1;
    assign done     = last || (!is_div && (b_q >> iters) == '0);
    assign prod_raw = {hi_n, lo_n} >> (CNT_W'(WIDTH) - iters);
`else
    assign done     = last;
    assign prod_raw = {hi_n, lo_n};
`endif
    assign neg = is_signed && (s1_q ^ s2_q);
    assign quo = neg ? -lo_n : lo_n;
    assign rem = (is_signed && s1_q) ? -hi_n : hi_n;
    assign fin = is_div ? {rem, quo} : (neg ? -prod_raw : prod_raw);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (start_i && !annul_i) ? (div_by_zero ? DIVZERO : RUN) : IDLE;
            DIVZERO: state_d = annul_i ? IDLE : (cnt_q[0] ? END : DIVZERO);
            RUN:     state_d = annul_i ? IDLE : (done ? END : RUN);
            END:     state_d = (annul_i || !start_i) ? IDLE : END;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            result_o   <= '0;
            ready_o    <= 1'b0;
            busy_o     <= 1'b0;
            div_zero_o <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            ready_o    <= state_d == END;
            busy_o     <= state_d == RUN || state_d == DIVZERO;
            div_zero_o <= state_d == END && (state_q == DIVZERO || div_zero_o);
            case (state_q)
                IDLE: if (state_d != IDLE) begin
                    op_q  <= op_i;
                    s1_q  <= op_i[0] && op1_i[WIDTH-1];
                    s2_q  <= op_i[0] && op2_i[WIDTH-1];
                    a_q   <= div_by_zero ? op1_i : abs1;
                    b_q   <= abs2;
                    hi_q  <= '0;
                    lo_q  <= op_i[1] ? abs1 : abs2;
                    cnt_q <= '0;
                end
                DIVZERO: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (state_d == END) result_o <= {a_q, {WIDTH{1'b1}}};
                end
                RUN: begin
                    hi_q  <= hi_n;
                    lo_q  <= lo_n;
                    cnt_q <= cnt_q + 1'b1;
                    if (state_d == END) result_o <= fin;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq at WIDTH=32.
module tb_muldiv_seq;
`ifdef MULDIV_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif
    localparam logic [1:0] MULTU = 2'd0, MULT = 2'd1, DIVU = 2'd2, DIV = 2'd3;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, annul = 1'b0;
    logic [1:0]  op = '0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [63:0] result;
    logic        ready, busy, div_zero;
    int          n_checks = 0, n_fail = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul), .op_i(op),
        .op1_i(op1), .op2_i(op2), .result_o(result), .ready_o(ready),
        .busy_o(busy), .div_zero_o(div_zero)
    );

    always #5 clk = ~clk;

    // Accept an op, scramble inputs afterwards, and count edges until ready (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic b1);
        op = o; op1 = x; op2 = y; start = 1'b1;
        @(posedge clk); #1;
        op1 = $urandom; op2 = $urandom; op = ~o;
        b1 = busy;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic finish_op;
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz got %b want 0", div_zero); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mult;
        int lat; logic b1;
        run_op(MULT, 32'hFFFFFFFD, 32'd7, lat, b1);
        n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL mult_busy got %b want 1", b1); end
        n_checks++; if (lat != (ET ? 3 : 32)) begin n_fail++; $display("FAIL mult_latency got %0d want %0d", lat, ET ? 3 : 32); end
        n_checks++; if (result !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL mult_result got %h want ffffffffffffffeb", result); end
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL mult_dz got %b want 0", div_zero); end
        @(posedge clk); #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL mult_hold_ready got %b want 1", ready); end
        finish_op();
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL mult_drop_ready got %b want 0", ready); end
        n_checks++; if (result !== 64'hFFFFFFFF_FFFFFFEB) begin n_fail++; $display("FAIL mult_result_hold got %h want ffffffffffffffeb", result); end
    endtask

    task automatic test_divide;
        logic [1:0]  ops[3] = '{DIV, DIVU, DIVU};
        logic [31:0] xs[3]  = '{32'hFFFFFFF9, 32'd100, 32'h7};
        logic [31:0] ys[3]  = '{32'd2, 32'd7, 32'h9};
        logic [63:0] ex[3]  = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000002_0000000E, 64'h00000007_00000000};
        int lat; logic b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], xs[i], ys[i], lat, b1);
            n_checks++; if (lat != 32) begin n_fail++; $display("FAIL div%0d_latency got %0d want 32", i, lat); end
            n_checks++; if (result !== ex[i]) begin n_fail++; $display("FAIL div%0d_result got %h want %h", i, result, ex[i]); end
            finish_op();
        end
    endtask

    task automatic test_divzero;
        int lat; logic b1;
        run_op(DIVU, 32'h1234, 32'h0, lat, b1);
        n_checks++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL dz_busy got %b want 1", b1); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL dz_latency got %0d want 2", lat); end
        n_checks++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag got %b want 1", div_zero); end
        n_checks++; if (result !== 64'h00001234_FFFFFFFF) begin n_fail++; $display("FAIL dz_result got %h want 00001234ffffffff", result); end
        finish_op();
        n_checks++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL dz_clear got %b want 0", div_zero); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL dz_ready_clear got %b want 0", ready); end
    endtask

    task automatic test_overflow;
        logic [1:0]  ops[3] = '{DIV, MULTU, MULT};
        logic [31:0] xs[3]  = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] ys[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [63:0] ex[3]  = '{64'h00000000_80000000, 64'hFFFFFFFE_00000001, 64'h40000000_00000000};
        int lat; logic b1;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], xs[i], ys[i], lat, b1);
            n_checks++; if (lat != 32) begin n_fail++; $display("FAIL ovf%0d_latency got %0d want 32", i, lat); end
            n_checks++; if (result !== ex[i]) begin n_fail++; $display("FAIL ovf%0d_result got %h want %h", i, result, ex[i]); end
            finish_op();
        end
    endtask

    task automatic test_annul;
        logic [63:0] prev;
        int rises, lat; logic b1;
        prev = result;
        op = MULTU; op1 = 32'd5; op2 = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL annul_busy got %b want 0", busy); end
        n_checks++; if (result !== prev) begin n_fail++; $display("FAIL annul_result got %h want %h", result, prev); end
        start = 1'b0; annul = 1'b0;
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) rises++;
        end
        n_checks++; if (rises != 0) begin n_fail++; $display("FAIL annul_ready got %0d ready cycles want 0", rises); end
        op = DIVU; op1 = 32'd9; op2 = 32'd3; start = 1'b1; annul = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL annul_start_busy got %b want 0", busy); end
        annul = 1'b0;
        run_op(DIVU, 32'd9, 32'd3, lat, b1);
        n_checks++; if (lat != 32) begin n_fail++; $display("FAIL annul_restart_latency got %0d want 32", lat); end
        n_checks++; if (result !== 64'h00000000_00000003) begin n_fail++; $display("FAIL annul_restart_result got %h want 3", result); end
        finish_op();
    endtask

    task automatic test_reset_midrun;
        op = MULTU; op1 = 32'd5; op2 = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL midrst_result got %h want 0", result); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got %b want 0", ready); end
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_early_term;
        int lat; logic b1;
        run_op(MULTU, 32'd7, 32'd3, lat, b1);
        n_checks++; if (lat != (ET ? 2 : 32)) begin n_fail++; $display("FAIL early_latency got %0d want %0d", lat, ET ? 2 : 32); end
        n_checks++; if (result !== 64'd21) begin n_fail++; $display("FAIL early_result got %h want 15", result); end
        finish_op();
    endtask

    task automatic test_back_to_back;
        int lat; logic b1;
        run_op(MULTU, 32'd1000, 32'd1000, lat, b1);
        n_checks++; if (result !== 64'd1000000) begin n_fail++; $display("FAIL b2b0_result got %h want f4240", result); end
        finish_op();
        run_op(DIV, 32'd7, 32'hFFFFFFFE, lat, b1);
        n_checks++; if (result !== 64'h00000001_FFFFFFFD) begin n_fail++; $display("FAIL b2b1_result got %h want 00000001fffffffd", result); end
        n_checks++; if (lat != 32) begin n_fail++; $display("FAIL b2b1_latency got %0d want 32", lat); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divide();
        test_divzero();
        test_overflow();
        test_annul();
        test_reset_midrun();
        test_early_term();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; radix-2, one iteration per cycle.
- Handles signed/unsigned multiply and signed/unsigned divide behind a single start/annul/ready handshake.
- EX holds `start_i` and stalls the pipeline until `ready_o`, then writes `result_o` to HI/LO.
- Moves multiply off the combinational EX path and generalises the divider to any operand width.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH; must be >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low (0 = reset, sampled on rising clk).
- start_i  in  1  request; held high by EX for the whole operation.
- annul_i  in  1  abort the current operation (flush/exception).
- op_i  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- op1_i  in  WIDTH  multiplicand / dividend.
- op2_i  in  WIDTH  multiplier / divisor.
- result_o  out  2*WIDTH  mul: full product {hi,lo}; div: {remainder, quotient}.
- ready_o  out  1  result valid.
- busy_o  out  1  high in RUN and DIVZERO.
- div_zero_o  out  1  divide by zero; valid while ready_o is high.

Behaviour:
- Reset (rst=0 at an edge): state=IDLE, result_o=0, ready_o=0, busy_o=0, div_zero_o=0, counter=0. Reset applies from any state, including mid-RUN.
- States: IDLE, DIVZERO, RUN, END.
- IDLE, start_i=1, annul_i=0:
  - Latch op_i.
  - Signed ops: latch |op1| and |op2| as WIDTH-bit unsigned values, plus the operand signs.
  - Divide with op2_i=0: go to DIVZERO.
  - Otherwise: go to RUN with counter=0.
- Operands are sampled only on the accepting edge. Later changes on op1_i/op2_i/op_i are ignored.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first.
- RUN, divide: restoring shift-subtract; a (WIDTH+1)-bit partial remainder produces one quotient bit per cycle.
- Leaving RUN: after WIDTH iterations go to END.
  - Sign correction is applied on this same edge.
  - MULT: product negated if the signs differ.
  - DIV: quotient negated if the signs differ; remainder takes the dividend's sign.
- Latency: ready_o rises on the WIDTH-th rising edge after the accepting edge. For WIDTH=32 that is 32 cycles.
- DIVZERO: one cycle, then END with result_o={op1_i latched, all-ones} and div_zero_o=1.
- END:
  - ready_o=1; result_o is stable.
  - Stays in END while start_i=1.
  - start_i=0 returns to IDLE; ready_o and div_zero_o clear on that edge.
  - result_o holds its last value until the next operation.
- annul_i=1 in RUN or DIVZERO: IDLE on the next edge, ready_o stays 0, result_o unchanged.
- annul_i=1 in END: IDLE.
- annul_i=1 and start_i=1 together in IDLE: annul wins and the start is not accepted.
- Overflow rules:
  - MIN/-1 (signed) gives quotient=MIN and remainder=0 (wraps, no trap).
  - MULT of MIN*MIN gives +2^(2*WIDTH-2), which is exact.
- start_i=0 during RUN with no annul: the operation completes, END is reached, and the unit returns to IDLE on the next edge.
- busy_o is registered, high exactly in RUN and DIVZERO.

Optional Feature:
- Macro: MULDIV_EARLY_TERM_EN.
- Defined: multiply leaves RUN as soon as all remaining multiplier bits are zero, after at least one iteration.
  - Latency = max(1, bit-length of |op2|) edges.
  - The product is shifted into final alignment on the exit edge.
  - Divide is unaffected.
- Undefined: fixed WIDTH-cycle latency for all ops; no leading-zero logic is synthesised.

Test Plan:
- MULT 0xFFFFFFFD * 0x00000007 (WIDTH=32), start held -> ready_o on the 32nd edge; result_o=0xFFFFFFFF_FFFFFFEB; drop start -> IDLE next edge.
- DIV 0xFFFFFFF9 (-7) / 2 -> result_o={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3); DIVU 100/7 -> {0x2, 0xE}.
- DIVU 0x1234 / 0 -> ready_o 2 edges after accept; div_zero_o=1; result_o={0x00001234, 0xFFFFFFFF}.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o={0x0, 0x80000000}; MULTU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE_00000001.
- Start MULTU, annul_i at iteration 10 -> IDLE next edge, ready_o never rises. Separately, rst=0 mid-RUN -> all outputs 0 on the next edge.
- With MULDIV_EARLY_TERM_EN defined, MULTU 7*3 -> ready_o 2 edges after accept, result 21; without it -> 32 edges, result 21.
